// File: rtl/npc_pkg.sv
// npc_pkg: shared register-file widths, zero-register index and index/word types
package npc_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int unsigned ZERO_IDX = 0;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one read port's zero-register, write-bypass and busy resolution
module rf_read_port
    import npc_pkg::*;
#(
    parameter int AW       = DEF_ADDR_WIDTH,
    parameter int DW       = DEF_DATA_WIDTH,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [AW-1:0] i_raddr,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_rf_data,
    input  logic          i_pend,
    output logic [DW-1:0] o_rdata,
    output logic          o_rbusy
);

    logic w_zero;
    logic w_hit;

    // Register 0 masks everything; a same-cycle write to the index overrides storage and clears busy
    always_comb begin
        w_zero  = ZERO_REG && (i_raddr == AW'(ZERO_IDX));
        w_hit   = BYPASS && i_wen && (i_waddr == i_raddr);
        o_rdata = w_zero ? '0 : w_hit ? i_wdata : i_rf_data;
        o_rbusy = !w_zero && i_pend && !w_hit;
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, single-write register file with pending-writer scoreboard
module regfile_sb
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NR_RPORTS  = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [NR_RPORTS*ADDR_WIDTH-1:0]  raddr,
    output logic [NR_RPORTS*DATA_WIDTH-1:0]  rdata,
    output logic [NR_RPORTS-1:0]             rbusy,
    input  logic                             issue_en,
    input  logic [ADDR_WIDTH-1:0]            issue_rd,
    output logic                             issue_ready
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]      r_pend;
    logic                  w_wzero;
    logic                  w_izero;
    logic                  w_wr;
    logic                  w_issue_acc;

    // Zero-register filtering and issue acceptance; a landing writeback releases a WAW stall
    always_comb begin
        w_wzero     = ZERO_REG && (waddr == ADDR_WIDTH'(ZERO_IDX));
        w_izero     = ZERO_REG && (issue_rd == ADDR_WIDTH'(ZERO_IDX));
        w_wr        = wen && !w_wzero;
        issue_ready = w_izero || !(r_pend[issue_rd] && !(wen && waddr == issue_rd));
        w_issue_acc = issue_en && issue_ready && !w_izero;
    end

    // Data array: writeback stores wdata, reset clears every register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rf <= '{default: '0};
        else if (w_wr)
            r_rf[waddr] <= wdata;
    end

    // Scoreboard: writeback clears, accepted issue sets; issue is applied last so it wins on a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            if (w_wr)
                r_pend[waddr] <= 1'b0;
            if (w_issue_acc)
                r_pend[issue_rd] <= 1'b1;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NR_RPORTS; p++) begin : g_rport
            logic [ADDR_WIDTH-1:0] w_a;
            assign w_a = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rf_read_port #(
                .AW       (ADDR_WIDTH),
                .DW       (DATA_WIDTH),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_port (
                .i_raddr   (w_a),
                .i_wen     (wen),
                .i_waddr   (waddr),
                .i_wdata   (wdata),
                .i_rf_data (r_rf[w_a]),
                .i_pend    (r_pend[w_a]),
                .o_rdata   (rdata[p*DATA_WIDTH +: DATA_WIDTH]),
                .o_rbusy   (rbusy[p])
            );
        end
    endgenerate

endmodule
